local_injection_ni: RTL and testbench

//  Injection network interface feeding the router LOCAL input port (upstream neighbour of the router).
//  - Accepts messages from the local core: destination X/Y plus 32-bit payload.
//  - Queues them and serialises each into a 4-flit packet: HEAD, BODY1, BODY2, TAIL (router_pkg FLIT_t).
//  - Credit-based flow control against the router input buffer; no backpressure wire on the flit link.

---
 rtl/local_injection_ni.sv | 143 ++++++++++++++
 tb/tb_local_injection_ni.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/local_injection_ni.sv
// Injection NI for the router LOCAL port: queues core messages and serialises each one
// into a HEAD/BODY1/BODY2/TAIL packet under credit-based flow control.
module local_injection_ni #(
  parameter int          CREDITS        = 4,
  parameter int          MSG_FIFO_DEPTH = 2,
  parameter logic [7:0]  SRC_X          = 8'd0,
  parameter logic [7:0]  SRC_Y          = 8'd0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             msg_valid,
  output logic                             msg_ready,
  input  logic [7:0]                       msg_dest_x,
  input  logic [7:0]                       msg_dest_y,
  input  logic [31:0]                      msg_data,
  output logic [18:0]                      flit_out,
  input  logic                             credit_in,
  output logic [$clog2(CREDITS+1)-1:0]     credit_cnt,
  output logic                             busy,
  output logic                             pkt_sent,
  output logic                             credit_err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int PW = (MSG_FIFO_DEPTH > 1) ? $clog2(MSG_FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CREDITS_W = CW'(CREDITS);
  localparam logic [PW:0]   DEPTH_W   = (PW + 1)'(MSG_FIFO_DEPTH);

  localparam logic [1:0] TYPE_HEAD = 2'd0;
  localparam logic [1:0] TYPE_TAIL = 2'd1;
  localparam logic [1:0] TYPE_BODY = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_BODY1, S_BODY2, S_TAIL} state_t;

  state_t            state_q, state_d;
  logic [47:0]       mem_q [MSG_FIFO_DEPTH];
  logic [47:0]       mem_d [MSG_FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [CW-1:0]     credit_cnt_q, credit_cnt_d;
  logic [18:0]       flit_q, flit_d;
  logic              pkt_sent_q, pkt_sent_d;
  logic              credit_err_q, credit_err_d;

  logic              push, pop, emit;
  logic [47:0]       head_msg;
  logic [18:0]       cur_flit;

  always_comb begin
    push     = msg_valid && (count_q != DEPTH_W);
    emit     = (state_q != S_IDLE) && (credit_cnt_q != '0);
    pop      = emit && (state_q == S_TAIL);
    head_msg = mem_q[rd_ptr_q];

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {msg_dest_x, msg_dest_y, msg_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end

    // State names the next flit to emit; emitting states advance only when a flit goes out.
    state_d  = state_q;
    cur_flit = '0;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_HEAD;
      S_HEAD: begin
        cur_flit = {1'b1, TYPE_HEAD, head_msg[47:32]};
        if (emit) state_d = S_BODY1;
      end
      S_BODY1: begin
        cur_flit = {1'b1, TYPE_BODY, head_msg[31:16]};
        if (emit) state_d = S_BODY2;
      end
      S_BODY2: begin
        cur_flit = {1'b1, TYPE_BODY, head_msg[15:0]};
        if (emit) state_d = S_TAIL;
      end
      S_TAIL: begin
        cur_flit = {1'b1, TYPE_TAIL, SRC_X, SRC_Y};
        if (emit) state_d = (count_d != '0) ? S_HEAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A returned credit that would overflow the counter is dropped and flagged.
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    if (emit && !credit_in) begin
      credit_cnt_d = credit_cnt_q - 1'b1;
    end else if (!emit && credit_in) begin
      if (credit_cnt_q == CREDITS_W) credit_err_d = 1'b1;
      else                           credit_cnt_d = credit_cnt_q + 1'b1;
    end

    flit_d     = emit ? cur_flit : '0;
    pkt_sent_d = pop;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      credit_cnt_q <= CREDITS_W;
      flit_q       <= '0;
      pkt_sent_q   <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      credit_cnt_q <= credit_cnt_d;
      flit_q       <= flit_d;
      pkt_sent_q   <= pkt_sent_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign msg_ready  = (count_q != DEPTH_W);
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign flit_out   = flit_q;
  assign credit_cnt = credit_cnt_q;
  assign pkt_sent   = pkt_sent_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_local_injection_ni.sv
// Directed bench for local_injection_ni: inputs change and outputs are checked on the
// falling edge, one linear step per clock cycle.
module tb_local_injection_ni;

  logic        clk;
  logic        rst;
  logic        msg_valid;
  logic        msg_ready;
  logic [7:0]  msg_dest_x;
  logic [7:0]  msg_dest_y;
  logic [31:0] msg_data;
  logic [18:0] flit_out;
  logic        credit_in;
  logic [2:0]  credit_cnt;
  logic        busy;
  logic        pkt_sent;
  logic        credit_err;

  int total = 0;
  int bad   = 0;

  local_injection_ni #(
    .CREDITS(4),
    .MSG_FIFO_DEPTH(2),
    .SRC_X(8'd0),
    .SRC_Y(8'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .msg_dest_x(msg_dest_x),
    .msg_dest_y(msg_dest_y),
    .msg_data(msg_data),
    .flit_out(flit_out),
    .credit_in(credit_in),
    .credit_cnt(credit_cnt),
    .busy(busy),
    .pkt_sent(pkt_sent),
    .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [7:0] x, input logic [7:0] y,
                               input logic [31:0] d, input logic cr);
    msg_valid  = v;
    msg_dest_x = x;
    msg_dest_y = y;
    msg_data   = d;
    credit_in  = cr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkFlit(input string tag, input logic [18:0] exp_flit,
                           input logic [2:0] exp_cnt);
    checkOutput({tag, "_flit"}, 32'(flit_out), 32'(exp_flit));
    checkOutput({tag, "_cnt"}, 32'(credit_cnt), 32'(exp_cnt));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 32'h0, 1'b0);
    repeat (3) cyc();

    // Reset values
    checkFlit("rst", 19'h0, 3'd4);
    checkOutput("rst_ready", 32'(msg_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pkt", 32'(pkt_sent), 32'd0);
    checkOutput("rst_err", 32'(credit_err), 32'd0);

    // Single packet dest(3,5) DEADBEEF with full credits
    rst = 1'b0;
    applyStimulus(1'b1, 8'd3, 8'd5, 32'hDEAD_BEEF, 1'b0);
    cyc();
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkFlit("t1_acc", 19'h0, 3'd4);
    applyStimulus(1'b0, 8'h00, 8'h00, 32'h0, 1'b0);
    cyc(); checkFlit("t1_lat", 19'h0, 3'd4);
    cyc(); checkFlit("t1_head", 19'h4_0305, 3'd3);
    cyc(); checkFlit("t1_body1", 19'h6_DEAD, 3'd2);
    cyc(); checkFlit("t1_body2", 19'h6_BEEF, 3'd1);
    checkOutput("t1_nopkt", 32'(pkt_sent), 32'd0);
    cyc(); checkFlit("t1_tail", 19'h5_0000, 3'd0);
    checkOutput("t1_pkt", 32'(pkt_sent), 32'd1);
    cyc(); checkFlit("t1_after", 19'h0, 3'd0);
    checkOutput("t1_pkt_off", 32'(pkt_sent), 32'd0);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    // No credits: queue A and B, hold C while queue is full
    applyStimulus(1'b1, 8'd1, 8'd2, 32'h1111_2222, 1'b0);
    cyc(); checkOutput("t2_ready_1", 32'(msg_ready), 32'd1);
    applyStimulus(1'b1, 8'd3, 8'd4, 32'h3333_4444, 1'b0);
    cyc(); checkOutput("t3_full", 32'(msg_ready), 32'd0);
    checkFlit("t2_stall0", 19'h0, 3'd0);
    checkOutput("t2_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 8'd5, 8'd6, 32'h5555_6666, 1'b0);
    cyc(); checkFlit("t2_stall1", 19'h0, 3'd0);
    checkOutput("t3_full2", 32'(msg_ready), 32'd0);
    credit_in = 1'b1;
    cyc(); checkFlit("t2_cr1", 19'h0, 3'd1);
    credit_in = 1'b0;
    cyc(); checkFlit("t2_headA", 19'h4_0102, 3'd0);
    credit_in = 1'b1;
    cyc(); checkFlit("t2_cr2", 19'h0, 3'd1);
    credit_in = 1'b0;
    cyc(); checkFlit("t2_body1A", 19'h6_1111, 3'd0);
    credit_in = 1'b1;
    cyc(); checkFlit("t2_cr3", 19'h0, 3'd1);
    cyc(); checkFlit("t2_body2A", 19'h6_2222, 3'd1);
    checkOutput("t3_full3", 32'(msg_ready), 32'd0);
    cyc(); checkFlit("t2_tailA", 19'h5_0000, 3'd1);
    checkOutput("t2_pktA", 32'(pkt_sent), 32'd1);
    checkOutput("t3_pop_ready", 32'(msg_ready), 32'd1);
    cyc(); checkFlit("t2_headB", 19'h4_0304, 3'd1);
    checkOutput("t3_refull", 32'(msg_ready), 32'd0);
    checkOutput("t2_pkt_off", 32'(pkt_sent), 32'd0);
    msg_valid = 1'b0;
    cyc(); checkFlit("t2_body1B", 19'h6_3333, 3'd1);
    cyc(); checkFlit("t2_body2B", 19'h6_4444, 3'd1);
    cyc(); checkFlit("t2_tailB", 19'h5_0000, 3'd1);
    checkOutput("t2_pktB", 32'(pkt_sent), 32'd1);
    cyc(); checkFlit("t3_headC", 19'h4_0506, 3'd1);
    cyc(); checkFlit("t3_body1C", 19'h6_5555, 3'd1);
    cyc(); checkFlit("t3_body2C", 19'h6_6666, 3'd1);
    cyc(); checkFlit("t3_tailC", 19'h5_0000, 3'd1);
    checkOutput("t3_pktC", 32'(pkt_sent), 32'd1);
    credit_in = 1'b0;
    cyc(); checkFlit("t3_done", 19'h0, 3'd1);
    checkOutput("t3_idle", 32'(busy), 32'd0);

    // Credit returned on the same edge as an emit leaves the count unchanged
    credit_in = 1'b1;
    cyc(); checkFlit("t4_cnt2", 19'h0, 3'd2);
    applyStimulus(1'b1, 8'd7, 8'd8, 32'h7777_8888, 1'b0);
    cyc(); applyStimulus(1'b0, 8'h00, 8'h00, 32'h0, 1'b0);
    cyc(); checkFlit("t4_pre", 19'h0, 3'd2);
    credit_in = 1'b1;
    cyc(); checkFlit("t4_headD", 19'h4_0708, 3'd2);
    credit_in = 1'b0;
    cyc(); checkFlit("t4_body1D", 19'h6_7777, 3'd1);
    cyc(); checkFlit("t4_body2D", 19'h6_8888, 3'd0);
    cyc(); checkFlit("t4_stallD", 19'h0, 3'd0);
    credit_in = 1'b1;
    cyc(); checkFlit("t4_cr", 19'h0, 3'd1);
    cyc(); checkFlit("t4_tailD", 19'h5_0000, 3'd1);
    cyc(); checkFlit("t4_c2", 19'h0, 3'd2);
    cyc(); checkFlit("t4_c3", 19'h0, 3'd3);
    cyc(); checkFlit("t4_c4", 19'h0, 3'd4);
    checkOutput("t4_err_clear", 32'(credit_err), 32'd0);
    cyc(); checkFlit("t4_ovf", 19'h0, 3'd4);
    checkOutput("t4_err_set", 32'(credit_err), 32'd1);
    credit_in = 1'b0;
    cyc(); checkOutput("t4_err_sticky", 32'(credit_err), 32'd1);

    // Reset in the middle of a packet
    applyStimulus(1'b1, 8'd9, 8'd10, 32'hAAAA_BBBB, 1'b0);
    cyc(); applyStimulus(1'b0, 8'h00, 8'h00, 32'h0, 1'b0);
    cyc(); checkFlit("t5_pre", 19'h0, 3'd4);
    cyc(); checkFlit("t5_headE", 19'h4_090A, 3'd3);
    rst = 1'b1;
    cyc(); checkFlit("t5_rst", 19'h0, 3'd4);
    checkOutput("t5_ready", 32'(msg_ready), 32'd1);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_err", 32'(credit_err), 32'd0);
    rst = 1'b0;
    cyc(); checkFlit("t5_quiet1", 19'h0, 3'd4);
    checkOutput("t5_busy2", 32'(busy), 32'd0);
    cyc(); checkFlit("t5_quiet2", 19'h0, 3'd4);
    checkOutput("t5_pkt", 32'(pkt_sent), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
